// File: rtl/pixel_block_loader.sv
// pixel_block_loader
//   Serial-to-parallel front end of the fixed-point stage. Collects a valid/ready
//   stream of unsigned pixels, in block order, into one packed block bus. Two banks
//   work as a ping-pong pair: one fills while the other is held for the consumer.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   pix_valid  in   pix_data / pix_first are valid
//   pix_ready  out  loader can accept a pixel (registered state only)
//   pix_data   in   unsigned pixel value
//   pix_first  in   pixel is element 0 of a new block
//   blk_valid  out  a full block is presented on integers
//   blk_ready  in   consumer takes the block
//   integers   out  element i at [i*INPUT_BITS +: INPUT_BITS]
//   blk_count  out  blocks delivered, wraps 0xFFFF -> 0
//   drop_err   out  one-cycle pulse: a partial block was discarded

module pixel_block_loader #(
    parameter int unsigned INPUT_BITS   = 8,
    parameter int unsigned NUM_INTEGERS = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_valid,
    output logic                               pix_ready,
    input  logic [INPUT_BITS-1:0]              pix_data,
    input  logic                               pix_first,
    output logic                               blk_valid,
    input  logic                               blk_ready,
    output logic [NUM_INTEGERS*INPUT_BITS-1:0] integers,
    output logic [15:0]                        blk_count,
    output logic                               drop_err
);

    localparam int unsigned IDX_W = $clog2(NUM_INTEGERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INTEGERS - 1);

    logic [INPUT_BITS-1:0] bank [2][NUM_INTEGERS];
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_next;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [IDX_W-1:0]      wr_idx;

    logic accept;
    logic take;
    logic restart;
    logic complete;

    assign pix_ready = !bank_full[wr_bank];
    assign blk_valid = bank_full[rd_bank];
    assign accept    = pix_valid && pix_ready;
    assign take      = blk_valid && blk_ready;

    // A first-flag in the middle of a block restarts the fill in the same bank.
    assign restart   = pix_first && (wr_idx != '0);
    assign complete  = !pix_first && (wr_idx == LAST_IDX);

    // Fill and take can never target the same bank: a filling bank is empty and a
    // taken bank is full, so both updates are applied independently.
    always_comb begin
        bank_full_next = bank_full;
        if (accept && complete) begin
            bank_full_next[wr_bank] = 1'b1;
        end
        if (take) begin
            bank_full_next[rd_bank] = 1'b0;
        end
    end

    always_comb begin
        integers = '0;
        for (int i = 0; i < int'(NUM_INTEGERS); i++) begin
            integers[i*INPUT_BITS +: INPUT_BITS] = bank[rd_bank][i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(NUM_INTEGERS); i++) begin
                    bank[b][i] <= '0;
                end
            end
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            blk_count <= '0;
            drop_err  <= 1'b0;
        end else begin
            drop_err  <= 1'b0;
            bank_full <= bank_full_next;

            if (accept) begin
                if (restart) begin
                    bank[wr_bank][0] <= pix_data;
                    wr_idx           <= IDX_W'(1);
                    drop_err         <= 1'b1;
                end else begin
                    bank[wr_bank][wr_idx] <= pix_data;
                    if (complete) begin
                        wr_bank <= !wr_bank;
                        wr_idx  <= '0;
                    end else begin
                        wr_idx <= wr_idx + IDX_W'(1);
                    end
                end
            end

            if (take) begin
                rd_bank   <= !rd_bank;
                blk_count <= blk_count + 16'd1;
            end
        end
    end

endmodule
